// File: rtl/fp_sched_pkg.sv
// ---------------------------------------------------------------------------
// fp_sched_pkg
// Shared definitions for the fixed-point operation scheduler: request
// opcodes and the sequencer state encoding.
// ---------------------------------------------------------------------------
package fp_sched_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_MUL  = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ADD_EXEC,
      DIV_START,
      DIV_WAIT,
      RESP
   } sched_state_t;

endpackage

// File: rtl/fp_op_scheduler_if.sv
// ---------------------------------------------------------------------------
// fp_op_scheduler_if
// Request/response bundle between the two requesters and the scheduler.
//   req_valid[1:0]  per-requester request valid
//   req_ready[1:0]  per-requester accept (one-hot or zero)
//   req_op0/1       opcodes, req_a0/b0/a1/b1 operands
//   rsp_valid/ready response handshake
//   rsp_id          requester that issued the op
//   rsp_data        result (0 on error), rsp_err error flag
// master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface fp_op_scheduler_if;

   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_op0;
   logic [1:0]  req_op1;
   logic [31:0] req_a0;
   logic [31:0] req_b0;
   logic [31:0] req_a1;
   logic [31:0] req_b1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
      input  req_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
      output req_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      input  rsp_ready
   );

endinterface

// File: rtl/fp_op_scheduler_arb.sv
// ---------------------------------------------------------------------------
// fp_rr_arb2
// Two-input round-robin grant. A lone request is granted outright; on a tie
// the requester other than last_grant wins. last_grant only moves when the
// caller reports an accept, so an unserved grant does not rotate priority.
//   clk, rst  clock, async active-high reset (last_grant resets to 1)
//   req       request bits
//   accept    update last_grant from the current grant
//   grant     one-hot grant, zero when no request
// ---------------------------------------------------------------------------
module fp_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // grant unassigned, which would infer a latch.
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/fp_op_scheduler.sv
// ---------------------------------------------------------------------------
// fp_op_scheduler
// Arbitrates two requesters onto the shared fixed-point adder (single cycle,
// combinational) and divider (start/complete handshake), then returns the
// result with the requester ID on a back-pressured response port. Mul and the
// reserved opcode, and divider hangs, come back as error responses.
//   DIV_TIMEOUT        max DIV_WAIT cycles before the divide is aborted
//   clk, rst           clock, async active-high reset
//   bus                request/response bundle (slave side)
//   add_a, add_b       registered adder operands; add_c adder result
//   div_a, div_b       registered dividend/divisor
//   div_start          one-cycle divider start pulse
//   div_q, div_complete divider quotient and done
// ---------------------------------------------------------------------------
module fp_op_scheduler
   import fp_sched_pkg::*;
#(
   parameter int DIV_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_op_scheduler_if.slave     bus,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   input  logic [31:0]          add_c,
   output logic [31:0]          div_a,
   output logic [31:0]          div_b,
   output logic                 div_start,
   input  logic [31:0]          div_q,
   input  logic                 div_complete
);

   // Counter only needs to reach DIV_TIMEOUT-1.
   localparam int               CNT_W    = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

   sched_state_t     state;
   logic [CNT_W-1:0] div_cnt;
   logic [1:0]       grant;
   logic [1:0]       req_ready_int;
   logic             accept;
   logic             sel_id;
   logic [1:0]       sel_op;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;

   fp_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bus.req_valid),
      .accept (accept),
      .grant  (grant)
   );

   // Ready is only offered while idle and out of reset; grant is already a
   // subset of req_valid, so any ready bit implies a handshake.
   assign req_ready_int = (state == IDLE && !rst) ? grant : 2'b00;
   assign bus.req_ready = req_ready_int;
   assign accept        = |req_ready_int;

   assign sel_id = grant[1];
   assign sel_op = sel_id ? bus.req_op1 : bus.req_op0;
   assign sel_a  = sel_id ? bus.req_a1  : bus.req_a0;
   assign sel_b  = sel_id ? bus.req_b1  : bus.req_b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         div_cnt       <= '0;
         div_start     <= 1'b0;
         add_a         <= '0;
         add_b         <= '0;
         div_a         <= '0;
         div_b         <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         // Pulse: only the IDLE->DIV_START transition raises it again.
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.rsp_id <= sel_id;
                  case (sel_op)
                     OP_ADD: begin
                        add_a <= sel_a;
                        add_b <= sel_b;
                        state <= ADD_EXEC;
                     end
                     OP_DIV: begin
                        div_a     <= sel_a;
                        div_b     <= sel_b;
                        div_start <= 1'b1;
                        state     <= DIV_START;
                     end
                     default: begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                     end
                  endcase
               end
            end
            ADD_EXEC: begin
               bus.rsp_data  <= add_c;
               bus.rsp_err   <= 1'b0;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            DIV_START: begin
               // div_complete is deliberately ignored in the start cycle.
               div_cnt <= '0;
               state   <= DIV_WAIT;
            end
            DIV_WAIT: begin
               // Complete is tested first so it wins over a same-cycle timeout.
               if (div_complete) begin
                  bus.rsp_data  <= div_q;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else if (div_cnt == CNT_LAST) begin
                  bus.rsp_data  <= '0;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
